// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the slave-to-master data-phase mux and its error responder.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    OK   = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } resp_fsm_e;

  // NONSEQ and SEQ are the only transfer types that demand a real response.
  function automatic logic trans_active(input logic [1:0] t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_err_resp.sv
// Two-cycle AHB ERROR responder: ERR1 holds the bus with ERROR, ERR2 completes it.
module ahb_err_resp
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic start_err,
  output logic err_active,
  output logic err_ready
);

  resp_fsm_e state, state_nxt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= OK;
    end else begin
      state <= state_nxt;
    end
  end

  // start_err is only honoured from OK; an error sequence always runs to completion.
  always_comb begin
    state_nxt  = state;
    err_active = 1'b0;
    err_ready  = 1'b1;
    case (state)
      OK: begin
        if (start_err) state_nxt = ERR1;
      end
      ERR1: begin
        state_nxt  = ERR2;
        err_active = 1'b1;
        err_ready  = 1'b0;
      end
      ERR2: begin
        state_nxt  = OK;
        err_active = 1'b1;
      end
      default: state_nxt = OK;
    endcase
  end

endmodule

// File: rtl/ahb_s2m_mux_n.sv
// AHB slave-to-master data-phase mux for NUM_SLV slaves plus a default slave,
// with an optional data-phase wait watchdog that terminates hung transfers with ERROR.
module ahb_s2m_mux_n
  import ahb_pkg::*;
#(
  parameter int NUM_SLV   = 3,
  parameter int DATA_BITS = 32,
  parameter int RESP_BITS = 2,
  parameter int TIMEOUT   = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [NUM_SLV-1:0]             HSEL,
  input  logic [1:0]                     HTRANS,
  input  logic [NUM_SLV*DATA_BITS-1:0]   HRDATA_S,
  input  logic [NUM_SLV-1:0]             HREADY_S,
  input  logic [NUM_SLV*RESP_BITS-1:0]   HRESP_S,
  output logic [DATA_BITS-1:0]           HRDATA,
  output logic                           HREADY,
  output logic [RESP_BITS-1:0]           HRESP,
  output logic                           timeout_o
);

  localparam logic [NUM_SLV:0] SEL_DEFAULT = (NUM_SLV+1)'(1);

  logic [NUM_SLV:0]      sel_q;
  logic [1:0]            htrans_q;
  logic                  hsel_onehot;
  logic                  err_active;
  logic                  err_ready;
  logic                  start_err;
  logic                  wd_fire;
  logic                  sel_ready;
  logic [DATA_BITS-1:0]  sel_data;
  logic [RESP_BITS-1:0]  sel_resp;

  assign hsel_onehot = (HSEL != '0) && ((HSEL & (HSEL - NUM_SLV'(1))) == '0);

  // Address phase -> data phase: capture owner and transfer type on every accepted beat.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q    <= SEL_DEFAULT;
      htrans_q <= IDLE;
    end else if (HREADY) begin
      sel_q    <= hsel_onehot ? {HSEL, 1'b0} : SEL_DEFAULT;
      htrans_q <= HTRANS;
    end
  end

  // sel_q is always one-hot, so at most one loop iteration overrides the default-slave values.
  always_comb begin
    sel_data  = '0;
    sel_resp  = RESP_BITS'(HRESP_OKAY);
    sel_ready = ~trans_active(htrans_q);
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i+1]) begin
        sel_data  = HRDATA_S[i*DATA_BITS +: DATA_BITS];
        sel_resp  = HRESP_S[i*RESP_BITS +: RESP_BITS];
        sel_ready = HREADY_S[i];
      end
    end
  end

  assign HREADY = err_active ? err_ready : sel_ready;
  assign HRESP  = err_active ? RESP_BITS'(HRESP_ERROR) : sel_resp;
  assign HRDATA = err_active ? '0 : sel_data;

  // Default-slave errors start from the address phase so ERR1 is the first data-phase cycle;
  // the second term covers an active default beat accepted during ERR2.
  assign start_err = (HREADY && !hsel_onehot && trans_active(HTRANS))
                   || (sel_q[0] && trans_active(htrans_q))
                   || wd_fire;

  ahb_err_resp u_err_resp (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start_err  (start_err),
    .err_active (err_active),
    .err_ready  (err_ready)
  );

  if (TIMEOUT == 0) begin : g_no_wd
    assign wd_fire = 1'b0;
  end else begin : g_wd
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic [CW-1:0] wait_cnt;
    logic          slave_wait;

    assign slave_wait = !err_active && !sel_q[0] && !sel_ready;

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        wait_cnt <= '0;
      end else if (HREADY) begin
        wait_cnt <= '0;
      end else if (slave_wait && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end

    assign wd_fire = slave_wait && (wait_cnt == CNT_LAST);
  end

  assign timeout_o = wd_fire;

endmodule
